// File: rtl/mixer_demod.sv
// rtl/mixer_demod.sv - NCO sine mixer with integrate-and-dump decimator for ADC samples

// Sine table, 127 * sin(2*pi*phase/256) rounded, stored as one quarter wave.
module sine_lookup (
  input  logic [7:0]        phase_i,
  output logic signed [7:0] sine_o
);

  logic [6:0] qidx;
  logic [6:0] mag;

  // Fold the falling quarters back onto the rising quarter (index 0..64).
  always_comb begin
    qidx = phase_i[6] ? (7'd64 - {1'b0, phase_i[5:0]}) : {1'b0, phase_i[5:0]};
  end

  // Quarter-wave magnitude table.
  always_comb begin
    mag = 7'd0;
    case (qidx)
      7'd0:  mag = 7'd0;   7'd1:  mag = 7'd3;   7'd2:  mag = 7'd6;   7'd3:  mag = 7'd9;
      7'd4:  mag = 7'd12;  7'd5:  mag = 7'd16;  7'd6:  mag = 7'd19;  7'd7:  mag = 7'd22;
      7'd8:  mag = 7'd25;  7'd9:  mag = 7'd28;  7'd10: mag = 7'd31;  7'd11: mag = 7'd34;
      7'd12: mag = 7'd37;  7'd13: mag = 7'd40;  7'd14: mag = 7'd43;  7'd15: mag = 7'd46;
      7'd16: mag = 7'd49;  7'd17: mag = 7'd51;  7'd18: mag = 7'd54;  7'd19: mag = 7'd57;
      7'd20: mag = 7'd60;  7'd21: mag = 7'd63;  7'd22: mag = 7'd65;  7'd23: mag = 7'd68;
      7'd24: mag = 7'd71;  7'd25: mag = 7'd73;  7'd26: mag = 7'd76;  7'd27: mag = 7'd78;
      7'd28: mag = 7'd81;  7'd29: mag = 7'd83;  7'd30: mag = 7'd85;  7'd31: mag = 7'd88;
      7'd32: mag = 7'd90;  7'd33: mag = 7'd92;  7'd34: mag = 7'd94;  7'd35: mag = 7'd96;
      7'd36: mag = 7'd98;  7'd37: mag = 7'd100; 7'd38: mag = 7'd102; 7'd39: mag = 7'd104;
      7'd40: mag = 7'd106; 7'd41: mag = 7'd107; 7'd42: mag = 7'd109; 7'd43: mag = 7'd111;
      7'd44: mag = 7'd112; 7'd45: mag = 7'd113; 7'd46: mag = 7'd115; 7'd47: mag = 7'd116;
      7'd48: mag = 7'd117; 7'd49: mag = 7'd118; 7'd50: mag = 7'd120; 7'd51: mag = 7'd121;
      7'd52: mag = 7'd122; 7'd53: mag = 7'd122; 7'd54: mag = 7'd123; 7'd55: mag = 7'd124;
      7'd56: mag = 7'd125; 7'd57: mag = 7'd125; 7'd58: mag = 7'd126; 7'd59: mag = 7'd126;
      7'd60: mag = 7'd126; 7'd61: mag = 7'd127; 7'd62: mag = 7'd127; 7'd63: mag = 7'd127;
      7'd64: mag = 7'd127;
      default: mag = 7'd0;
    endcase
  end

  // Second half of the cycle is the negated first half.
  always_comb begin
    sine_o = phase_i[7] ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
  end

endmodule

// Mixes offset-binary samples with the NCO sine and dumps 2^DECIM_LOG2-sample sums.
module mixer_demod #(
  parameter int DECIM_LOG2 = 4,
  parameter int ACC_W      = 16 + DECIM_LOG2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_sample,
  input  logic       in_valid,
  input  logic [7:0] freq_word,
  input  logic [7:0] phase_ofs,
  input  logic       phase_clr,
  output logic [7:0] out_data,
  output logic       out_valid
);

  localparam int                      SHIFT    = DECIM_LOG2 + 7;
  localparam logic [DECIM_LOG2-1:0]   CNT_LAST = '1;
  localparam logic signed [ACC_W-1:0] SAT_HI   = 127;
  localparam logic signed [ACC_W-1:0] SAT_LO   = -128;

  // NCO
  logic [7:0] phase_acc_q, phase_acc_d;
  logic [7:0] phase_base;

  // S1: signed sample and lookup phase
  logic              s1_valid_q, s1_valid_d;
  logic signed [7:0] s1_sample_q, s1_sample_d;
  logic [7:0]        s1_phase_q, s1_phase_d;

  // S2: sine value and sample
  logic              s2_valid_q, s2_valid_d;
  logic signed [7:0] s2_sine_q, s2_sine_d;
  logic signed [7:0] s2_sample_q, s2_sample_d;
  logic signed [7:0] sine_w;

  // S3: product
  logic               s3_valid_q, s3_valid_d;
  logic signed [15:0] s3_prod_q, s3_prod_d;

  // S4: integrator and output
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_w;
  logic signed [ACC_W-1:0] shifted_w;
  logic [7:0]              sat_w;

  sine_lookup u_sine (
    .phase_i (s1_phase_q),
    .sine_o  (sine_w)
  );

  // NCO advance and S1 capture; phase_clr restarts the phase before this sample.
  always_comb begin
    phase_base  = phase_clr ? 8'h00 : phase_acc_q;
    phase_acc_d = in_valid ? (phase_base + freq_word) : phase_base;
    s1_valid_d  = in_valid;
    s1_sample_d = in_valid ? $signed(in_sample ^ 8'h80) : s1_sample_q;
    s1_phase_d  = in_valid ? (phase_base + phase_ofs) : s1_phase_q;
  end

  // S2/S3 data path; phase_clr drops anything already in flight.
  always_comb begin
    s2_valid_d  = s1_valid_q & ~phase_clr;
    s2_sine_d   = s1_valid_q ? sine_w : s2_sine_q;
    s2_sample_d = s1_valid_q ? s1_sample_q : s2_sample_q;
    s3_valid_d  = s2_valid_q & ~phase_clr;
    s3_prod_d   = s2_valid_q ? (s2_sample_q * s2_sine_q) : s3_prod_q;
  end

  // Dump value: floor-scaled block sum, clamped to the signed 8-bit range.
  always_comb begin
    prod_ext  = {{(ACC_W-16){s3_prod_q[15]}}, s3_prod_q};
    sum_w     = acc_q + prod_ext;
    shifted_w = sum_w >>> SHIFT;
    if (shifted_w > SAT_HI) begin
      sat_w = 8'h7f;
    end else if (shifted_w < SAT_LO) begin
      sat_w = 8'h80;
    end else begin
      sat_w = shifted_w[7:0];
    end
  end

  // Integrate products; the last product of a block produces the strobe.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (phase_clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s3_valid_q) begin
      if (cnt_q != CNT_LAST) begin
        acc_d = sum_w;
        cnt_d = cnt_q + 1'b1;
      end else begin
        acc_d       = '0;
        cnt_d       = '0;
        out_data_d  = sat_w;
        out_valid_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc_q <= 8'h00;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= 8'sh00;
      s1_phase_q  <= 8'h00;
      s2_valid_q  <= 1'b0;
      s2_sine_q   <= 8'sh00;
      s2_sample_q <= 8'sh00;
      s3_valid_q  <= 1'b0;
      s3_prod_q   <= 16'sh0000;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      phase_acc_q <= phase_acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_phase_q  <= s1_phase_d;
      s2_valid_q  <= s2_valid_d;
      s2_sine_q   <= s2_sine_d;
      s2_sample_q <= s2_sample_d;
      s3_valid_q  <= s3_valid_d;
      s3_prod_q   <= s3_prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
